// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment encoder/decoder pair:
// active-low segment patterns (g..a), digit count and scan FSM states.
package seg_pkg;

   localparam int SEG_DIGITS = 8;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h18;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_HOLD
   } state_t;

   // True when exactly one anode is driven low.
   function automatic logic onehot_low(input logic [7:0] a);
      logic [7:0] v;
      v = ~a;
      return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
   endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational lookup from an active-low 7-bit segment pattern to its hex nibble;
// hit is low for any pattern outside the sixteen hex glyphs.
module seg_pattern_decode
   import seg_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       hit
);

   always_comb begin
      nibble = 4'h0;
      hit    = 1'b1;
      case (pattern)
         SEG_0:   nibble = 4'h0;
         SEG_1:   nibble = 4'h1;
         SEG_2:   nibble = 4'h2;
         SEG_3:   nibble = 4'h3;
         SEG_4:   nibble = 4'h4;
         SEG_5:   nibble = 4'h5;
         SEG_6:   nibble = 4'h6;
         SEG_7:   nibble = 4'h7;
         SEG_8:   nibble = 4'h8;
         SEG_9:   nibble = 4'h9;
         SEG_A:   nibble = 4'hA;
         SEG_B:   nibble = 4'hB;
         SEG_C:   nibble = 4'hC;
         SEG_D:   nibble = 4'hD;
         SEG_E:   nibble = 4'hE;
         SEG_F:   nibble = 4'hF;
         default: hit    = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Reconstructs the hex value shown on a multiplexed active-low 7-segment bus.
// Define SEG_SCAN_DP_EN to capture decimal points; otherwise seg[7] is ignored and dp is 0.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  seg,
   input  logic [7:0]  an,
   output logic [31:0] value,
   output logic [7:0]  digit_valid,
   output logic        frame_valid,
   output logic        err,
   output logic [7:0]  dp
);

   localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);
`ifdef SEG_SCAN_DP_EN
   localparam logic DP_EN = 1'b1;
`else
   localparam logic DP_EN = 1'b0;
`endif

   logic [7:0] seg_q, an_q, seg_m;
   logic [7:0] cnt_reg, cnt_next;
   state_t     state_reg, state_next;
   logic       changed, sample, hit;
   logic [3:0] nibble;
   logic [2:0] idx;
   logic [7:0] dv_reg, dv_set;
   logic       fv_reg, err_reg;
   logic [3:0] value_reg [SEG_DIGITS];

   // With decimal points disabled, dp toggles must not restart debouncing.
   assign seg_m   = {seg[7] | ~DP_EN, seg[6:0]};
   // Comparing the raw bus against its registered copy flags a change one cycle early,
   // so a change arriving on the sampling cycle suppresses that sample.
   assign changed = ({an, seg_m} != {an_q, seg_q});

   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q     <= 8'hFF;
         an_q      <= 8'hFF;
         cnt_reg   <= 8'd0;
         state_reg <= ST_IDLE;
      end else begin
         seg_q     <= seg_m;
         an_q      <= an;
         cnt_reg   <= cnt_next;
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      sample     = 1'b0;
      if (changed) begin
         cnt_next   = 8'd0;
         state_next = onehot_low(an) ? ST_SETTLE : ST_IDLE;
      end else begin
         if (cnt_reg < STABLE_LIM)
            cnt_next = cnt_reg + 8'd1;
         if (state_reg == ST_SETTLE && cnt_next == STABLE_LIM) begin
            sample     = 1'b1;
            state_next = ST_HOLD;
         end
      end
   end

   always_comb begin
      idx = 3'd0;
      for (int i = 0; i < SEG_DIGITS; i++)
         if (!an_q[i])
            idx = 3'(i);
   end

   seg_pattern_decode u_decode (
      .pattern (seg_q[6:0]),
      .nibble  (nibble),
      .hit     (hit)
   );

   assign dv_set = dv_reg | (8'b1 << idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         dv_reg  <= 8'h00;
         fv_reg  <= 1'b0;
         err_reg <= 1'b0;
      end else begin
         fv_reg <= 1'b0;
         if (sample) begin
            if (!hit) begin
               err_reg <= 1'b1;
            end else if (dv_set == 8'hFF) begin
               fv_reg <= 1'b1;
               dv_reg <= 8'h00;
            end else begin
               dv_reg <= dv_set;
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < SEG_DIGITS; gi++) begin : g_digit
         always_ff @(posedge clk) begin
            if (rst)
               value_reg[gi] <= 4'h0;
            else if (sample && hit && idx == 3'(gi))
               value_reg[gi] <= nibble;
         end
         assign value[4*gi +: 4] = value_reg[gi];
`ifdef SEG_SCAN_DP_EN
         logic dp_reg;
         always_ff @(posedge clk) begin
            if (rst)
               dp_reg <= 1'b0;
            else if (sample && idx == 3'(gi))
               dp_reg <= ~seg_q[7];
         end
         assign dp[gi] = dp_reg;
`else
         assign dp[gi] = 1'b0;
`endif
      end
   endgenerate

   assign digit_valid = dv_reg;
   assign frame_valid = fv_reg;
   assign err         = err_reg;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus a randomized scan,
// all checked against a run-length reference model of the display bus.
module tb_seg_scan_decoder;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  seg, an;
   logic [31:0] value;
   logic [7:0]  digit_valid;
   logic        frame_valid;
   logic        err;
   logic [7:0]  dp;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] pats [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state
   logic [31:0] m_value;
   logic [7:0]  m_dv, m_dp;
   logic        m_err;
   logic [15:0] m_prev;
   int          m_run;
   int          m_fv_cnt = 0;
   int          fv_seen  = 0;

   seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg         (seg),
      .an          (an),
      .value       (value),
      .digit_valid (digit_valid),
      .frame_valid (frame_valid),
      .err         (err),
      .dp          (dp)
   );

   always #5 clk = ~clk;

   // A digit is taken once the bus has held one value for S+1 consecutive edges.
   task automatic model_step();
      logic [7:0] s;
      int nz, pos;
      bit hit;
      logic [3:0] nib;
      if (rst) begin
         m_value = '0; m_dv = '0; m_dp = '0; m_err = 1'b0;
         m_prev = 16'hFFFF; m_run = 0;
         return;
      end
      s = seg;
`ifndef SEG_SCAN_DP_EN
      s[7] = 1'b1;
`endif
      if ({an, s} != m_prev) begin
         m_prev = {an, s};
         m_run  = 1;
      end else if (m_run < 1000) begin
         m_run++;
      end
      if (m_run == S + 1) begin
         nz = 0; pos = 0;
         for (int i = 0; i < 8; i++) if (!an[i]) begin nz++; pos = i; end
         if (nz == 1) begin
            hit = 0; nib = 0;
            for (int k = 0; k < 16; k++) if (s[6:0] == pats[k]) begin hit = 1; nib = 4'(k); end
            if (hit) begin
               m_value[4*pos +: 4] = nib;
               m_dv[pos] = 1'b1;
               if (m_dv == 8'hFF) begin
                  m_dv = 8'h00;
                  m_fv_cnt++;
               end
            end else begin
               m_err = 1'b1;
            end
`ifdef SEG_SCAN_DP_EN
            m_dp[pos] = ~s[7];
`endif
         end
      end
   endtask

   // Entered at a negedge; drives the bus for n cycles and returns at a negedge.
   task automatic drive(input logic [7:0] a, input logic [7:0] s, input int n);
      an = a; seg = s;
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (frame_valid) fv_seen++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(8'hFF, 8'hFF, 2);
      rst = 1'b0;
   endtask

   task automatic scan_word(input logic [31:0] w, input int cyc);
      for (int d = 0; d < 8; d++) begin
         logic [7:0] a;
         a = ~(8'b1 << d);
         drive(a, {1'b1, pats[w[4*d +: 4]]}, cyc);
      end
   endtask

   task automatic test_reset();
      drive(8'hFE, 8'hFF, 6);
      drive(8'hEF, {1'b1, pats[7]}, 6);
      rst = 1'b1;
      drive(8'hEF, {1'b1, pats[7]}, 1);
      n_checks++;
      if ({value, digit_valid, frame_valid, err, dp} !== 50'd0) begin
         n_fail++;
         $display("FAIL reset_state: got value=%h dv=%h fv=%b err=%b dp=%h, want all zero",
                  value, digit_valid, frame_valid, err, dp);
      end
      rst = 1'b0;
      drive(8'hFF, 8'hFF, 1);
      $display("test_reset: value=%h dv=%h err=%b", value, digit_valid, err);
   endtask

   task automatic test_single();
      do_reset();
      drive(8'hFE, 8'hC0, 4);
      n_checks++;
      if (digit_valid !== 8'h00) begin
         n_fail++;
         $display("FAIL single_early: got dv=%h, want 00 one cycle before sample", digit_valid);
      end
      drive(8'hFE, 8'hC0, 1);
      n_checks++;
      if ({value[3:0], digit_valid, err} !== {4'h0, 8'h01, 1'b0}) begin
         n_fail++;
         $display("FAIL single_sample: got nib=%h dv=%h err=%b, want 0 01 0",
                  value[3:0], digit_valid, err);
      end
      drive(8'hFE, 8'hC0, 5);
      n_checks++;
      if ({value, digit_valid, err, dp} !== {m_value, m_dv, m_err, m_dp}) begin
         n_fail++;
         $display("FAIL single_model: got %h/%h/%b/%h want %h/%h/%b/%h",
                  value, digit_valid, err, dp, m_value, m_dv, m_err, m_dp);
      end
      $display("test_single: value=%h dv=%h", value, digit_valid);
   endtask

   task automatic test_frame();
      int f0;
      do_reset();
      f0 = fv_seen;
      scan_word(32'h12345678, 6);
      n_checks++;
      if ({value, digit_valid} !== {32'h12345678, 8'h00}) begin
         n_fail++;
         $display("FAIL frame_value: got value=%h dv=%h, want 12345678 00", value, digit_valid);
      end
      n_checks++;
      if (fv_seen - f0 !== 1) begin
         n_fail++;
         $display("FAIL frame_pulse: got %0d frame pulses, want 1", fv_seen - f0);
      end
      $display("test_frame: value=%h pulses=%0d", value, fv_seen - f0);
   endtask

   task automatic test_blank();
      drive(8'hF7, 8'hFF, 8);
      n_checks++;
      if ({err, digit_valid[3], value} !== {1'b1, 1'b0, 32'h12345678}) begin
         n_fail++;
         $display("FAIL blank_err: got err=%b dv3=%b value=%h, want 1 0 12345678",
                  err, digit_valid[3], value);
      end
      drive(8'hFE, {1'b1, pats[8]}, 6);
      n_checks++;
      if ({err, digit_valid} !== {1'b1, 8'h01}) begin
         n_fail++;
         $display("FAIL blank_sticky: got err=%b dv=%h, want 1 01", err, digit_valid);
      end
      $display("test_blank: err=%b dv=%h", err, digit_valid);
   endtask

   task automatic test_glitch();
      do_reset();
      for (int t = 0; t < 8; t++)
         drive(8'hFB, {1'b1, (t % 2 == 0) ? pats[3] : pats[9]}, 3);
      drive(8'hFD, {1'b1, pats[1]}, 4);
      drive(8'hFD, {1'b1, pats[2]}, 1);
      n_checks++;
      if ({value, digit_valid} !== 40'd0) begin
         n_fail++;
         $display("FAIL glitch_reject: got value=%h dv=%h, want 0 00", value, digit_valid);
      end
      drive(8'hFB, {1'b1, pats[7]}, 5);
      n_checks++;
      if ({value[11:8], digit_valid} !== {4'h7, 8'h04}) begin
         n_fail++;
         $display("FAIL glitch_hold: got nib=%h dv=%h, want 7 04", value[11:8], digit_valid);
      end
      $display("test_glitch: value=%h dv=%h", value, digit_valid);
   endtask

   task automatic test_idle();
      do_reset();
      drive(8'hFC, {1'b1, pats[5]}, 20);
      drive(8'hFF, {1'b1, pats[5]}, 20);
      n_checks++;
      if ({value, digit_valid, err} !== 41'd0) begin
         n_fail++;
         $display("FAIL idle_nosample: got value=%h dv=%h err=%b, want 0 00 0",
                  value, digit_valid, err);
      end
      $display("test_idle: value=%h dv=%h err=%b", value, digit_valid, err);
   endtask

   task automatic test_reset_mid();
      int f0;
      do_reset();
      for (int d = 0; d < 5; d++) begin
         logic [7:0] a;
         a = ~(8'b1 << d);
         drive(a, {1'b1, pats[d + 10]}, 6);
      end
      rst = 1'b1;
      drive(8'hEF, {1'b1, pats[14]}, 1);
      n_checks++;
      if ({value, digit_valid, err, dp} !== 49'd0) begin
         n_fail++;
         $display("FAIL midreset_clear: got value=%h dv=%h err=%b dp=%h, want zeros",
                  value, digit_valid, err, dp);
      end
      rst = 1'b0;
      f0 = fv_seen;
      scan_word(32'h9ABCDEF0, 6);
      n_checks++;
      if ({value, fv_seen - f0} !== {32'h9ABCDEF0, 32'd1}) begin
         n_fail++;
         $display("FAIL midreset_frame: got value=%h pulses=%0d, want 9abcdef0 1",
                  value, fv_seen - f0);
      end
      $display("test_reset_mid: value=%h pulses=%0d", value, fv_seen - f0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 250; t++) begin
         logic [7:0] a, s;
         int n;
         if ($urandom_range(0, 9) < 8) a = ~(8'b1 << $urandom_range(0, 7));
         else                          a = 8'($urandom);
         if ($urandom_range(0, 19) < 17) s = {1'($urandom), pats[$urandom_range(0, 15)]};
         else                            s = 8'($urandom);
         n = $urandom_range(1, 8);
         drive(a, s, n);
         n_checks++;
         if ({value, digit_valid, err, dp, fv_seen} !== {m_value, m_dv, m_err, m_dp, m_fv_cnt}) begin
            n_fail++;
            $display("FAIL random_%0d: got %h/%h/%b/%h/%0d want %h/%h/%b/%h/%0d", t,
                     value, digit_valid, err, dp, fv_seen,
                     m_value, m_dv, m_err, m_dp, m_fv_cnt);
         end
      end
      $display("test_random: value=%h dv=%h err=%b frames=%0d", value, digit_valid, err, fv_seen);
   endtask

   initial begin
      rst = 1'b1; an = 8'hFF; seg = 8'hFF;
      m_value = '0; m_dv = '0; m_dp = '0; m_err = 1'b0; m_prev = 16'hFFFF; m_run = 0;
      @(negedge clk);
      test_reset();
      test_single();
      test_frame();
      test_blank();
      test_glitch();
      test_idle();
      test_reset_mid();
      do_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the hex-to-seven-segment encoder: watches the multiplexed, active-low seven-segment bus (segments plus digit anodes) and reconstructs the hexadecimal value being displayed. It sits between the board display pins (or the display driver's outputs) and the on-chip debug/self-check logic, so the CPU test harness can read back what the display shows. Each scanned digit is debounced over a programmable number of stable cycles, decoded, and stored; a frame strobe fires once all eight digits have been captured.

## Interface
- STABLE_CYCLES, default 4: consecutive cycles `{an, seg}` must be unchanged before a digit is sampled; legal range 1..255.
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- seg  in  8  segment bus, active-low; bit 7 = dp, bits 6:0 = g..a.
- an  in  8  digit anodes, active-low; exactly one low selects digit index 0..7.
- value  out  32  captured digits; digit i occupies bits [4i+3:4i]; reset 0.
- digit_valid  out  8  bit i set once digit i has been captured in the current frame; reset 0.
- frame_valid  out  1  one-cycle pulse when all eight digits are captured; reset 0.
- err  out  1  sticky: unrecognised segment pattern seen on a sampled digit; cleared only by rst; reset 0.
- dp  out  8  captured decimal-point state per digit, active-high (1 = lit); reset 0.

## Operation
- Inputs pass through one register stage (`seg_q`, `an_q`) before any use.
- Stability counter: cleared when `{an_q, seg_q}` differs from the previous cycle; otherwise increments, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: `an_q` not one-hot-low, i.e. all ones or several zeros. Nothing is sampled.
  - SETTLE: `an_q` one-hot; counter below STABLE_CYCLES.
  - HOLD: the digit has been sampled; wait here until the inputs change.
- Transitions:
  - Any input change goes to SETTLE if `an_q` is one-hot, otherwise to IDLE.
  - SETTLE goes to HOLD on the cycle the counter reaches STABLE_CYCLES. That cycle performs exactly one sample.
- Sample action for digit i:
  - Decode `seg_q[6:0]`: 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x18→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F.
  - On a hit: write the nibble into digit i of `value` and set `digit_valid[i]`.
  - On a miss: set `err`; `value` and `digit_valid[i]` are unchanged.
  - `dp[i]` takes `~seg_q[7]` on every sample, hit or miss (see Configuration).
- Frame handling:
  - When `digit_valid` would become 0xFF, pulse `frame_valid` and clear `digit_valid` to 0 on that same edge.
  - `value` keeps its contents across frames.
- Re-sampling the same digit within a frame overwrites its nibble; this is not an error.
- A sampled miss does not block the frame, but that digit stays invalid until it is sampled again with a good pattern.
- Reset mid-scan: every output returns to its reset value on the next edge, the FSM goes to IDLE, and the counter clears.

## Timing
- Latency: inputs stable and presented before edge n are registered at edge n. The sample and output updates are visible after edge n+STABLE_CYCLES.
- Glitches shorter than STABLE_CYCLES+1 cycles are never sampled.
- `frame_valid` is asserted in the same cycle the eighth `digit_valid` bit would appear.
- An input change on the sampling cycle itself takes priority: no sample, and the counter clears.

## Configuration
- SEG_SCAN_DP_EN:
  - Defined: `dp` captures the decimal points as described in Operation.
  - Undefined: `seg[7]` is ignored and `dp` is tied to 0. The port stays present.

## Structure
- Shared package `seg_pkg` holds:
  - the sixteen 7-bit segment pattern constants, shared with the encoder;
  - `SEG_DIGITS = 8`;
  - the FSM state typedef.
- One combinational sub-module, `seg_pattern_decode`: input 7-bit pattern; outputs 4-bit nibble and `hit`.

## Test plan
- After reset, hold an=0xFE, seg=0xC0 for 10 cycles → sample occurs exactly 4 cycles after registering; value[3:0]=0, digit_valid=0x01, err=0.
- Scan digits 0..7 showing 0x12345678 (digit 0 = 8), 6 cycles each → after the 8th sample value=0x12345678, frame_valid pulses once, digit_valid=0.
- Hold seg=0xFF (blank) on digit 3 → err=1 and stays set; digit_valid[3]=0; value unchanged.
- With STABLE_CYCLES=4, toggle seg every 3 cycles on a selected digit → no sample, value unchanged; then hold 5 cycles → sample occurs.
- an=0xFC (two digits low) with a valid pattern for 20 cycles → no update and no err; an=0xFF also idles.
- Assert rst mid-frame after 5 digits → next cycle value=0, digit_valid=0, err=0, dp=0; the following scan restarts the frame count from digit 0.
